// File: rtl/hub75_pkg.sv
// Shared constants, bus payload type and pixel packing helper for the HUB75 panel receiver.
package hub75_pkg;

  localparam int unsigned WIDTH_DEF = 64;
  localparam int unsigned ROWS_DEF  = 16;
  localparam int unsigned SYNC_DEF  = 2;
  localparam int unsigned PIX_BITS  = 3;
  localparam int unsigned ADDR_W    = 4;
  localparam int unsigned FRAME_W   = 16;

  // Bit offsets of the colour channels inside one packed pixel {R,G,B}.
  localparam int unsigned R_OFS = 2;
  localparam int unsigned G_OFS = 1;
  localparam int unsigned B_OFS = 0;

  typedef logic [PIX_BITS-1:0] pix_t;

  // Level-only bus lines that travel through the synchronizer together.
  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    pix_t              top;
    pix_t              bot;
    logic              oe;
  } bus_data_t;

  function automatic pix_t pix_pack(input logic r, input logic g, input logic b);
    pix_t p;
    p        = '0;
    p[R_OFS] = r;
    p[G_OFS] = g;
    p[B_OFS] = b;
    return p;
  endfunction

endpackage

// File: rtl/hub75_if.sv
// HUB75 panel bus as driven by a panel controller (master) and seen by a panel (slave).
interface hub75_if;

  logic clk_shft;
  logic A, B, C, D;
  logic R0, G0, B0;
  logic R1, G1, B1;
  logic OE;
  logic LAT;

  modport master (output clk_shft, A, B, C, D, R0, G0, B0, R1, G1, B1, OE, LAT);
  modport slave  (input  clk_shft, A, B, C, D, R0, G0, B0, R1, G1, B1, OE, LAT);

endinterface

// File: rtl/hub75_sync_edge.sv
// SYNC-deep synchronizer for a group of bus bits, with optional rising-edge detect
// taken between the last stage and one extra history flop.
module hub75_sync_edge #(
  parameter int unsigned W    = 1,
  parameter int unsigned SYNC = 2,
  parameter bit          EDGE = 1'b1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d,
  output logic [W-1:0] q,
  output logic [W-1:0] rise
);

  logic [W-1:0] stg [SYNC];

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < SYNC; i++) stg[i] <= '0;
    end else begin
      stg[0] <= d;
      for (int i = 1; i < SYNC; i++) stg[i] <= stg[i-1];
    end
  end

  assign q = stg[SYNC-1];

  // Edge form keeps one more sample so the edge lines up with q.
  if (EDGE) begin : g_edge
    logic [W-1:0] prev;
    always_ff @(posedge clk) begin
      if (!rst) prev <= '0;
      else      prev <= stg[SYNC-1];
    end
    assign rise = stg[SYNC-1] & ~prev;
  end else begin : g_level
    assign rise = '0;
  end

endmodule

// File: rtl/hub75_panel_rx.sv
// HUB75 receive-side panel model: rebuilds shifted rows, reports latched rows,
// completed frames and bus protocol violations.
module hub75_panel_rx
  import hub75_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEF,
  parameter int unsigned ROWS  = ROWS_DEF,
  parameter int unsigned SYNC  = SYNC_DEF
) (
  input  logic                      clk,
  input  logic                      rst,
  hub75_if.slave                    bus,
  output logic                      row_valid,
  output logic [ADDR_W-1:0]         row_addr,
  output logic [PIX_BITS*WIDTH-1:0] row_top,
  output logic [PIX_BITS*WIDTH-1:0] row_bot,
  output logic                      frame_done,
  output logic [FRAME_W-1:0]        frame_cnt,
  output logic                      len_err,
  output logic                      seq_err,
  output logic                      ghost_err,
  output logic                      lat_shf_err
);

  localparam int unsigned ROW_W  = PIX_BITS * WIDTH;
  localparam int unsigned CNT_W  = $clog2(WIDTH + 2);
  localparam int unsigned DATA_W = $bits(bus_data_t);
  localparam logic [CNT_W-1:0]  CNT_FULL = CNT_W'(WIDTH);
  localparam logic [CNT_W-1:0]  CNT_SAT  = CNT_W'(WIDTH + 1);
  localparam logic [ADDR_W-1:0] LAST_ROW = ADDR_W'(ROWS - 1);

  logic              shf_rise, shf_lvl_unused;
  logic              lat_rise, lat_lvl;
  bus_data_t         bd_in, bd;
  logic [DATA_W-1:0] data_rise_unused;

  hub75_sync_edge #(.W(1), .SYNC(SYNC), .EDGE(1'b1)) u_shf (
    .clk(clk), .rst(rst), .d(bus.clk_shft), .q(shf_lvl_unused), .rise(shf_rise)
  );

  hub75_sync_edge #(.W(1), .SYNC(SYNC), .EDGE(1'b1)) u_lat (
    .clk(clk), .rst(rst), .d(bus.LAT), .q(lat_lvl), .rise(lat_rise)
  );

  assign bd_in = {bus.D, bus.C, bus.B, bus.A,
                  pix_pack(bus.R0, bus.G0, bus.B0),
                  pix_pack(bus.R1, bus.G1, bus.B1),
                  bus.OE};

  hub75_sync_edge #(.W(DATA_W), .SYNC(SYNC), .EDGE(1'b0)) u_data (
    .clk(clk), .rst(rst), .d(bd_in), .q(bd), .rise(data_rise_unused)
  );

  logic [ROW_W-1:0]  top_sr, bot_sr, top_nx, bot_nx;
  logic [CNT_W-1:0]  cnt, cnt_nx;
  logic [ADDR_W-1:0] exp_row;
  logic              do_shift;

  // A shift coinciding with the LAT rise still lands in the row being latched.
  always_comb begin
    do_shift = shf_rise && (!lat_lvl || lat_rise);
    top_nx   = top_sr;
    bot_nx   = bot_sr;
    cnt_nx   = cnt;
    if (do_shift) begin
      top_nx = {top_sr[ROW_W-PIX_BITS-1:0], bd.top};
      bot_nx = {bot_sr[ROW_W-PIX_BITS-1:0], bd.bot};
      if (cnt != CNT_SAT) cnt_nx = cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      top_sr      <= '0;
      bot_sr      <= '0;
      cnt         <= '0;
      exp_row     <= '0;
      row_valid   <= 1'b0;
      row_addr    <= '0;
      row_top     <= '0;
      row_bot     <= '0;
      frame_done  <= 1'b0;
      frame_cnt   <= '0;
      len_err     <= 1'b0;
      seq_err     <= 1'b0;
      ghost_err   <= 1'b0;
      lat_shf_err <= 1'b0;
    end else begin
      row_valid   <= 1'b0;
      frame_done  <= 1'b0;
      len_err     <= 1'b0;
      seq_err     <= 1'b0;
      ghost_err   <= lat_rise && !bd.oe;
      lat_shf_err <= shf_rise && lat_lvl && !lat_rise;
      top_sr      <= top_nx;
      bot_sr      <= bot_nx;
      cnt         <= cnt_nx;
      if (lat_rise) begin
        row_valid <= 1'b1;
        row_addr  <= bd.addr;
        row_top   <= top_nx;
        row_bot   <= bot_nx;
        len_err   <= (cnt_nx != CNT_FULL);
        cnt       <= '0;
        // Expected-row tracking: in-order rows complete a frame, a stray 0 restarts one.
        if (bd.addr == exp_row) begin
          if (bd.addr == LAST_ROW) begin
            frame_done <= 1'b1;
            frame_cnt  <= frame_cnt + FRAME_W'(1);
            exp_row    <= '0;
          end else begin
            exp_row <= exp_row + ADDR_W'(1);
          end
        end else begin
          seq_err <= 1'b1;
          exp_row <= (bd.addr == '0) ? ADDR_W'(1) : '0;
        end
      end
    end
  end

endmodule

// File: tb/tb_hub75_panel_rx.sv
// Directed bench for hub75_panel_rx: a pixel-history model predicts every output each
// cycle, and hand-computed literals pin the key scenarios.
module tb_hub75_panel_rx;
  import hub75_pkg::*;

  localparam int unsigned W   = 64;
  localparam int unsigned RW  = 3 * W;
  localparam int unsigned LAT_CYC = 3;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  hub75_if bus();

  logic          row_valid, frame_done, len_err, seq_err, ghost_err, lat_shf_err;
  logic [3:0]    row_addr;
  logic [RW-1:0] row_top, row_bot;
  logic [15:0]   frame_cnt;

  hub75_panel_rx dut (
    .clk(clk), .rst(rst), .bus(bus),
    .row_valid(row_valid), .row_addr(row_addr), .row_top(row_top), .row_bot(row_bot),
    .frame_done(frame_done), .frame_cnt(frame_cnt), .len_err(len_err),
    .seq_err(seq_err), .ghost_err(ghost_err), .lat_shf_err(lat_shf_err)
  );

  typedef struct packed {
    logic       shf, lat, oe;
    logic [3:0] addr;
    logic [2:0] top, bot;
  } pins_t;

  typedef struct packed {
    logic          rv;
    logic [3:0]    addr;
    logic [RW-1:0] top, bot;
    logic          fd;
    logic [15:0]   fc;
    logic          le, se, ge, lse;
  } exp_t;

  int n_chk = 0, n_pass = 0, cyc = 0;
  int rv_seen = 0, fd_seen = 0, le_seen = 0, se_seen = 0, ge_seen = 0, lse_seen = 0;
  int rv_cyc = 0, lat_cyc = 0;
  pins_t cur, prev_p;
  logic  rst_drv = 1'b0, model_on = 1'b0;
  exp_t  exp_q[$];
  exp_t  ce;

  // Model state: every accepted pixel in shift order, plus the row/frame bookkeeping.
  logic [2:0]    hist_t[$], hist_b[$];
  int            m_cnt, m_exp;
  logic [3:0]    h_addr;
  logic [RW-1:0] h_top, h_bot;
  logic [15:0]   h_fc;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(input string nm, input logic [RW-1:0] act, input logic [RW-1:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h (cycle %0d)", nm, act, exp, cyc);
  endfunction

  task automatic drive();
    bus.clk_shft = cur.shf;
    bus.LAT      = cur.lat;
    bus.OE       = cur.oe;
    {bus.D, bus.C, bus.B, bus.A}  = cur.addr;
    {bus.R0, bus.G0, bus.B0}      = cur.top;
    {bus.R1, bus.G1, bus.B1}      = cur.bot;
  endtask

  task automatic model_reset();
    exp_t z;
    z = '0;
    hist_t.delete(); hist_b.delete();
    m_cnt = 0; m_exp = 0; h_addr = '0; h_top = '0; h_bot = '0; h_fc = '0;
    prev_p = '0;
    exp_q.delete();
    repeat (LAT_CYC) exp_q.push_back(z);
  endtask

  // Apply the pin vector of this cycle to the model and queue the outputs it implies.
  task automatic model_step();
    exp_t e;
    logic sr, lr, lse;
    e   = '0;
    sr  = cur.shf && !prev_p.shf;
    lr  = cur.lat && !prev_p.lat;
    lse = sr && cur.lat && !lr;
    if (sr && !lse) begin
      hist_t.push_back(cur.top);
      hist_b.push_back(cur.bot);
      if (hist_t.size() > W) begin
        void'(hist_t.pop_front());
        void'(hist_b.pop_front());
      end
      if (m_cnt < W + 1) m_cnt++;
    end
    if (lr) begin
      e.rv   = 1'b1;
      h_addr = cur.addr;
      h_top  = '0;
      h_bot  = '0;
      for (int c = 0; c < W; c++) begin
        if (c < hist_t.size()) begin
          h_top[3*c +: 3] = hist_t[hist_t.size()-1-c];
          h_bot[3*c +: 3] = hist_b[hist_b.size()-1-c];
        end
      end
      e.le  = (m_cnt != W);
      m_cnt = 0;
      if (int'(cur.addr) == m_exp) begin
        if (cur.addr == 4'd15) begin
          e.fd = 1'b1; h_fc = h_fc + 16'd1; m_exp = 0;
        end else m_exp++;
      end else begin
        e.se  = 1'b1;
        m_exp = (cur.addr == 4'd0) ? 1 : 0;
      end
    end
    e.ge   = lr && !cur.oe;
    e.lse  = lse;
    e.addr = h_addr; e.top = h_top; e.bot = h_bot; e.fc = h_fc;
    exp_q.push_back(e);
    prev_p = cur;
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
    rst = rst_drv;
    drive();
    if (rst_drv) begin
      if (!model_on) begin
        model_reset();
        model_on = 1'b1;
      end
      model_step();
    end
  endtask

  // Compare DUT against the model every cycle once the pipeline is primed.
  always @(negedge clk) begin
    if (row_valid)   begin rv_seen++; rv_cyc = cyc; end
    if (frame_done)  fd_seen++;
    if (len_err)     le_seen++;
    if (seq_err)     se_seen++;
    if (ghost_err)   ge_seen++;
    if (lat_shf_err) lse_seen++;
    if (exp_q.size() > LAT_CYC) begin
      ce = exp_q.pop_front();
      chk("row_valid",   RW'(row_valid),   RW'(ce.rv));
      chk("row_addr",    RW'(row_addr),    RW'(ce.addr));
      chk("row_top",     row_top,          ce.top);
      chk("row_bot",     row_bot,          ce.bot);
      chk("frame_done",  RW'(frame_done),  RW'(ce.fd));
      chk("frame_cnt",   RW'(frame_cnt),   RW'(ce.fc));
      chk("len_err",     RW'(len_err),     RW'(ce.le));
      chk("seq_err",     RW'(seq_err),     RW'(ce.se));
      chk("ghost_err",   RW'(ghost_err),   RW'(ce.ge));
      chk("lat_shf_err", RW'(lat_shf_err), RW'(ce.lse));
    end
  end

  task automatic do_reset();
    model_on = 1'b0;
    exp_q.delete();
    rst_drv  = 1'b0;
    cur.shf = 1'b0; cur.lat = 1'b0; cur.oe = 1'b1;
    repeat (4) tick();
    chk("rst_row_valid", RW'(row_valid), '0);
    chk("rst_frame_cnt", RW'(frame_cnt), '0);
    chk("rst_row_top",   row_top,        '0);
    chk("rst_len_err",   RW'(len_err),   '0);
    rst_drv = 1'b1;
  endtask

  task automatic shift1(input logic [2:0] t, input logic [2:0] b);
    cur.top = t; cur.bot = b; cur.shf = 1'b1; tick();
    cur.shf = 1'b0; tick();
  endtask

  task automatic shifts(input int n);
    logic [2:0] p;
    for (int i = 0; i < n; i++) begin
      p = 3'(i % 8);
      shift1(p, ~p);
    end
  endtask

  task automatic latch(input logic [3:0] a);
    cur.addr = a; cur.lat = 1'b1; tick();
    lat_cyc = cyc;
    cur.lat = 1'b0; tick();
  endtask

  task automatic row(input logic [3:0] a);
    shifts(W);
    latch(a);
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  initial begin
    int s_rv, s_fd, s_le, s_se, s_ge, s_lse;
    cur = '0; cur.oe = 1'b1;
    drive();
    do_reset();

    // Idle bus: no pulses at all.
    s_rv = rv_seen; s_fd = fd_seen; s_le = le_seen; s_se = se_seen; s_ge = ge_seen; s_lse = lse_seen;
    idle(1000);
    chk("idle_pulses", RW'((rv_seen-s_rv)+(fd_seen-s_fd)+(le_seen-s_le)+(se_seen-s_se)+(ge_seen-s_ge)+(lse_seen-s_lse)), '0);

    // Single full row at address 5 (out of order from reset).
    s_rv = rv_seen; s_le = le_seen; s_se = se_seen;
    row(4'd5);
    idle(6);
    chk("row5_pulse",   RW'(rv_seen - s_rv), RW'(1));
    chk("row5_latency", RW'(rv_cyc - lat_cyc), RW'(LAT_CYC));
    chk("row5_addr",    RW'(row_addr), RW'(5));
    chk("row5_top63",   RW'(row_top[3*63 +: 3]), RW'(0));
    chk("row5_top0",    RW'(row_top[2:0]), RW'(7));
    chk("row5_bot63",   RW'(row_bot[3*63 +: 3]), RW'(7));
    chk("row5_len_err", RW'(le_seen - s_le), RW'(0));
    chk("row5_seq_err", RW'(se_seen - s_se), RW'(1));

    // Three clean frames.
    s_fd = fd_seen; s_se = se_seen;
    for (int f = 0; f < 3; f++)
      for (int r = 0; r < 16; r++) row(4'(r));
    idle(6);
    chk("frames_cnt",  RW'(frame_cnt), RW'(3));
    chk("frames_done", RW'(fd_seen - s_fd), RW'(3));
    chk("frames_seq",  RW'(se_seen - s_se), RW'(0));

    // Broken sequence, then a full frame.
    s_fd = fd_seen; s_se = se_seen;
    row(4'd0); row(4'd1); row(4'd2); row(4'd7);
    idle(6);
    chk("skip_seq_err", RW'(se_seen - s_se), RW'(1));
    for (int r = 0; r < 16; r++) row(4'(r));
    idle(6);
    chk("skip_frame_cnt", RW'(frame_cnt), RW'(4));
    chk("skip_done",      RW'(fd_seen - s_fd), RW'(1));

    // Short row, then a row whose last shift coincides with LAT.
    s_le = le_seen;
    shifts(63); latch(4'd0);
    idle(6);
    chk("short_len_err", RW'(le_seen - s_le), RW'(1));
    s_le = le_seen; s_lse = lse_seen; s_se = se_seen;
    shifts(63);
    cur.top = 3'd5; cur.bot = 3'd2; cur.addr = 4'd1; cur.shf = 1'b1; cur.lat = 1'b1; tick();
    cur.shf = 1'b0; cur.lat = 1'b0; tick();
    idle(6);
    chk("sim_len_err", RW'(le_seen - s_le), RW'(0));
    chk("sim_lse",     RW'(lse_seen - s_lse), RW'(0));
    chk("sim_seq",     RW'(se_seen - s_se), RW'(0));
    chk("sim_top0",    RW'(row_top[2:0]), RW'(5));
    chk("sim_bot0",    RW'(row_bot[2:0]), RW'(2));

    // LAT rising while LEDs are lit.
    s_ge = ge_seen;
    cur.oe = 1'b0; tick();
    latch(4'd2);
    cur.oe = 1'b1; idle(6);
    chk("ghost", RW'(ge_seen - s_ge), RW'(1));

    // Shift edge while LAT is held high is rejected.
    s_lse = lse_seen;
    cur.addr = 4'd3; cur.lat = 1'b1; tick();
    cur.top = 3'd2; cur.bot = 3'd6; cur.shf = 1'b1; tick();
    cur.shf = 1'b0; tick();
    cur.lat = 1'b0; tick();
    latch(4'd6);
    idle(6);
    chk("lse_pulse", RW'(lse_seen - s_lse), RW'(1));
    chk("lse_top0",  RW'(row_top[2:0]), RW'(5));

    // Reset in the middle of a row.
    row(4'd0); row(4'd1);
    shifts(10);
    do_reset();
    s_le = le_seen; s_se = se_seen;
    shifts(20); latch(4'd0);
    idle(6);
    chk("mid_rst_len_err", RW'(le_seen - s_le), RW'(1));
    chk("mid_rst_seq_err", RW'(se_seen - s_se), RW'(0));
    chk("mid_rst_frames",  RW'(frame_cnt), RW'(0));
    chk("mid_rst_addr",    RW'(row_addr), RW'(0));

    idle(4);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: run did not complete, checks %0d/%0d", n_pass, n_chk);
    $fatal(1, "timeout");
  end

endmodule
